chassis_slot_scheduler: RTL
===========================

Name: chassis_slot_scheduler

Overview:
- Time-division scheduler that shares one wheel-update engine (PWM reload / encoder latch) among the four chassis wheel channels.
- A free-running frame counter splits each PERIOD into four equal slots. At each slot boundary the owning channel, if it is requesting, gets a one-cycle start and a one-hot grant until the engine reports done.
- Sits between the per-wheel control logic and the shared update engine, on the F50M domain.

Parameters:
- PERIOD, 2000000, frame length in F50M cycles; must be a multiple of 4 and ≥ 8.
- CNT_W, 21, frame counter width; must satisfy 2^CNT_W > PERIOD.
- TIMEOUT, 1024, maximum cycles to wait for done before aborting.
- TO_W, 11, timeout counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- F50M  in  1  system clock, 50 MHz.
- RESET  in  1  synchronous reset, active-high.
- en  in  1  scheduler enable.
- req  in  4  per-channel update request; level, sampled at the channel's slot boundary.
- done  in  1  one-cycle completion pulse from the shared engine.
- clr_err  in  1  clears the sticky error flags.
- start  out  1  one-cycle launch pulse to the engine.
- sel  out  2  index of the granted channel; holds its value between grants.
- grant  out  4  one-hot owner of the engine; all zero when idle.
- slot_tick  out  1  one-cycle pulse at every slot boundary.
- overrun  out  4  sticky: the channel's slot was lost because the engine was busy.
- timeout_err  out  1  sticky: the engine failed to return done within TIMEOUT.

Behaviour:
- Reset:
  - Reset is synchronous, active-high, and overrides all other logic.
  - All outputs, the counters and the FSM go to 0 / IDLE.
- Frame counter `cnt`:
  - Counts 0..PERIOD-1 and wraps to 0.
  - Increments only while en=1; en=0 forces cnt to 0 on the next edge.
- Slot boundaries:
  - Q = PERIOD/4. A boundary for slot k (k = 0..3) is the cycle where en=1 and cnt == k*Q.
  - slot_tick is registered: it is high on the cycle after the boundary.
- FSM states: IDLE, WAIT.
  - IDLE, on a boundary for slot k with req[k]=1: next cycle start=1, sel=k, grant=one-hot(k), timeout counter cleared; go to WAIT.
  - IDLE, on a boundary with req[k]=0: slot is skipped; stay in IDLE with no flags set.
  - WAIT: grant held and start=0; the timeout counter increments each cycle.
  - WAIT, done=1: grant goes to 0 on the next cycle; go to IDLE.
  - WAIT, timeout counter reaches TIMEOUT-1 with no done: set timeout_err, grant goes to 0, go to IDLE.
  - WAIT, a boundary for slot k arrives with req[k]=1 and no done in the same cycle: set overrun[k]; the request is dropped, never queued.
- Latency: boundary on cycle N gives start and grant high on cycle N+1, regardless of the en value on N+1. Minimum grant length is 1 cycle.
- Simultaneous events:
  - done and a requested boundary in the same WAIT cycle: the new slot is serviced back-to-back (start plus new grant on the next cycle, stay in WAIT); no overrun.
  - done and timeout in the same cycle: done wins; no timeout_err.
  - done received while in IDLE is ignored.
  - clr_err and a flag set in the same cycle: the set wins.
- en deasserted mid-transaction: the current grant completes normally (done or timeout); no new grants are issued while en=0.
- RESET mid-transaction: grant is dropped immediately; the engine must tolerate an abandoned job.

Decomposition:
- Shared package `chassis_pkg`:
  - FSM state encoding (IDLE=0, WAIT=1).
  - NUM_WHEELS=4.
  - Slot index type (2 bits).
  - Default PERIOD/TIMEOUT constants shared with the divider.
- Sub-module `slot_timer`: owns the frame counter, boundary detection and slot_tick generation. Outputs `boundary` and `slot_idx` to the FSM top level.

Test Plan (PERIOD=16, Q=4, TIMEOUT=8):
- RESET=1 for 3 cycles, then en=1, req=4'b0000 -> slot_tick every 4 cycles; start and grant stay 0; overrun=0, timeout_err=0.
- req=4'b0101, done returned 2 cycles after each start -> grant=0001 at cnt 1, grant=0100 at cnt 9; start is one cycle wide; sel=0 then 2.
- req[0]=1 at boundary 0 and done withheld 9 cycles -> grant 0001 held 8 cycles, timeout_err=1, grant returns to 0; a late done is ignored.
- req=4'b0011, done withheld until cycle 6 after start -> overrun[1]=1 at the slot-1 boundary; no second start; clr_err pulse -> overrun=0.
- req=4'b0011, done coincident with the slot-1 boundary -> start high next cycle with grant=0010 and no overrun.
- en dropped one cycle after a start, done 3 cycles later -> grant completes normally; no further starts; cnt=0 while en=0. RESET asserted mid-WAIT -> grant=0 on the next cycle.

Source files
------------

// File: rtl/chassis_pkg.sv
// Shared definitions for the chassis wheel-update slot scheduler.
// Contents: wheel count, slot index type, FSM state encoding, default frame/timeout
// constants shared with the divider, and a one-hot helper for grants.
package chassis_pkg;

  localparam int unsigned NUM_WHEELS      = 4;
  localparam int unsigned DEFAULT_PERIOD  = 2000000;
  localparam int unsigned DEFAULT_CNT_W   = 21;
  localparam int unsigned DEFAULT_TIMEOUT = 1024;
  localparam int unsigned DEFAULT_TO_W    = 11;

  typedef logic [1:0] slot_idx_t;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StWait = 1'b1
  } sched_state_e;

  function automatic logic [NUM_WHEELS-1:0] slot_onehot(slot_idx_t idx);
    return NUM_WHEELS'(1) << idx;
  endfunction

endpackage

// File: rtl/chassis_slot_scheduler_if.sv
// Handshake bundle between the per-wheel control logic, the scheduler and the
// shared wheel-update engine.
//   master: scheduler side (consumes en/req/done/clr_err, drives start/sel/grant,
//           slot_tick and the sticky error flags)
//   slave:  control/engine side, the mirror image
interface chassis_slot_scheduler_if import chassis_pkg::*; ();

  logic                  en;
  logic [NUM_WHEELS-1:0] req;
  logic                  done;
  logic                  clr_err;
  logic                  start;
  slot_idx_t             sel;
  logic [NUM_WHEELS-1:0] grant;
  logic                  slot_tick;
  logic [NUM_WHEELS-1:0] overrun;
  logic                  timeout_err;

  modport master (
    input  en, req, done, clr_err,
    output start, sel, grant, slot_tick, overrun, timeout_err
  );

  modport slave (
    output en, req, done, clr_err,
    input  start, sel, grant, slot_tick, overrun, timeout_err
  );

endinterface

// File: rtl/slot_timer.sv
// Frame counter and slot boundary detector.
//   F50M/RESET : clock and synchronous active-high reset
//   en         : counting enable; low parks the counter at 0
//   boundary   : combinational, high on the first cycle of a slot while en=1
//   slot_idx   : slot owning the current boundary (valid with boundary)
//   slot_tick  : registered copy of boundary (one cycle later)
module slot_timer import chassis_pkg::*; #(
  parameter int unsigned PERIOD = DEFAULT_PERIOD,
  parameter int unsigned CNT_W  = DEFAULT_CNT_W
) (
  input  logic      F50M,
  input  logic      RESET,
  input  logic      en,
  output logic      boundary,
  output slot_idx_t slot_idx,
  output logic      slot_tick
);

  localparam int unsigned Q = PERIOD / NUM_WHEELS;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             slot_tick_q, slot_tick_d;

  // Compare against the four fixed slot starts instead of a modulo.
  always_comb begin
    boundary = 1'b0;
    slot_idx = '0;
    for (int unsigned k = 0; k < NUM_WHEELS; k++) begin
      if (cnt_q == CNT_W'(k * Q)) begin
        boundary = en;
        slot_idx = slot_idx_t'(k);
      end
    end
  end

  always_comb begin
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(PERIOD - 1)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    slot_tick_d = boundary;
  end

  always_ff @(posedge F50M) begin
    if (RESET) begin
      cnt_q       <= '0;
      slot_tick_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      slot_tick_q <= slot_tick_d;
    end
  end

  assign slot_tick = slot_tick_q;

endmodule

// File: rtl/chassis_slot_scheduler.sv
// Time-division scheduler sharing one wheel-update engine among four wheels.
//   F50M/RESET : clock and synchronous active-high reset
//   bus        : master side of chassis_slot_scheduler_if (en, req, done, clr_err in;
//                start, sel, grant, slot_tick, overrun, timeout_err out)
// At each slot boundary the owning wheel, if requesting, gets a one-cycle start and a
// one-hot grant held until done or until TIMEOUT cycles pass.
module chassis_slot_scheduler import chassis_pkg::*; #(
  parameter int unsigned PERIOD  = DEFAULT_PERIOD,
  parameter int unsigned CNT_W   = DEFAULT_CNT_W,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  parameter int unsigned TO_W    = DEFAULT_TO_W
) (
  input logic                       F50M,
  input logic                       RESET,
  chassis_slot_scheduler_if.master  bus
);

  logic      boundary;
  slot_idx_t slot_idx;
  logic      want;

  slot_timer #(
    .PERIOD (PERIOD),
    .CNT_W  (CNT_W)
  ) u_slot_timer (
    .F50M      (F50M),
    .RESET     (RESET),
    .en        (bus.en),
    .boundary  (boundary),
    .slot_idx  (slot_idx),
    .slot_tick (bus.slot_tick)
  );

  sched_state_e          state_q, state_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic                  start_q, start_d;
  slot_idx_t             sel_q, sel_d;
  logic [NUM_WHEELS-1:0] grant_q, grant_d;
  logic [NUM_WHEELS-1:0] overrun_q, overrun_d;
  logic                  timeout_err_q, timeout_err_d;

  logic [NUM_WHEELS-1:0] ov_set;
  logic                  to_set;
  logic                  launch;

  assign want = boundary && bus.req[slot_idx];

  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    start_d  = 1'b0;
    sel_d    = sel_q;
    grant_d  = grant_q;
    ov_set   = '0;
    to_set   = 1'b0;
    launch   = 1'b0;

    case (state_q)
      StIdle: begin
        // done while idle is deliberately ignored
        launch = want;
      end
      StWait: begin
        if (bus.done) begin
          // A requested boundary coinciding with done is serviced back-to-back.
          if (want) begin
            launch = 1'b1;
          end else begin
            grant_d = '0;
            state_d = StIdle;
          end
        end else begin
          if (want) begin
            ov_set[slot_idx] = 1'b1;
          end
          if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
            to_set  = 1'b1;
            grant_d = '0;
            state_d = StIdle;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (launch) begin
      start_d  = 1'b1;
      sel_d    = slot_idx;
      grant_d  = slot_onehot(slot_idx);
      to_cnt_d = '0;
      state_d  = StWait;
    end

    // Setting a flag takes priority over clearing it in the same cycle.
    overrun_d     = (bus.clr_err ? '0 : overrun_q) | ov_set;
    timeout_err_d = (bus.clr_err ? 1'b0 : timeout_err_q) | to_set;
  end

  always_ff @(posedge F50M) begin
    if (RESET) begin
      state_q       <= StIdle;
      to_cnt_q      <= '0;
      start_q       <= 1'b0;
      sel_q         <= '0;
      grant_q       <= '0;
      overrun_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      to_cnt_q      <= to_cnt_d;
      start_q       <= start_d;
      sel_q         <= sel_d;
      grant_q       <= grant_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.start       = start_q;
  assign bus.sel         = sel_q;
  assign bus.grant       = grant_q;
  assign bus.overrun     = overrun_q;
  assign bus.timeout_err = timeout_err_q;

endmodule
